// File: rtl/hex_frame_dumper.sv
// rtl/hex_frame_dumper.sv - ASCII-hex dump of a result memory frame to a UART
//
// Walks a synchronous-read result memory from address 0 to DEPTH-1 on a start
// pulse and emits every word as uppercase hex digits. Words are separated by a
// space, and every WORDS_PER_LINE words (and after the last word) by CR LF.
// Bytes are handed to an acia_tx-style transmitter via tx_start/tx_busy.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start_i      dump request pulse, honoured only while idle
//   busy_o       frame in progress
//   done_o       one-cycle pulse once the last byte has left the UART
//   rd_addr_o    result memory read address
//   rd_data_i    result memory data, one cycle after rd_addr_o
//   tx_dat_o     byte to UART, valid while tx_start_o is high
//   tx_start_o   one-cycle transmit trigger
//   tx_busy_i    UART busy, rises the cycle after tx_start_o
module hex_frame_dumper #(
  parameter int DATA_W         = 16,
  parameter int DEPTH          = 64,
  parameter int ADDR_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic [7:0]        tx_dat_o,
  output logic              tx_start_o,
  input  logic              tx_busy_i
);

  localparam int NIB    = (DATA_W + 3) / 4;
  localparam int WORD_W = 4 * NIB;
  localparam int DIG_W  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int LINE_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(WORDS_PER_LINE - 1);
  localparam logic [LINE_W-1:0] LINE_ONE  = LINE_W'(1);
  localparam logic [DIG_W-1:0]  DIG_TOP   = DIG_W'(NIB - 1);
  localparam logic [DIG_W-1:0]  DIG_ONE   = DIG_W'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_DIGIT = 3'd3;
  localparam logic [2:0] S_SEP   = 3'd4;
  localparam logic [2:0] S_CR    = 3'd5;
  localparam logic [2:0] S_LF    = 3'd6;
  localparam logic [2:0] S_DRAIN = 3'd7;

  // Sub-phase shared by all byte-emitting states.
  localparam logic PH_SEND = 1'b0;
  localparam logic PH_GAP  = 1'b1;

  logic [2:0]        state_q, state_d;
  logic              phase_q, phase_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [DIG_W-1:0]  dig_q, dig_d;
  logic [7:0]        tx_dat_q, tx_dat_d;
  logic              tx_start_q, tx_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [3:0]        nib;
  logic [7:0]        hex_char;
  logic [7:0]        cur_byte;
  logic              end_of_line;

  assign nib      = word_q[{dig_q, 2'b00} +: 4];
  assign hex_char = (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});

  // The last word of the frame always closes its line, whatever the count.
  assign end_of_line = (line_q == LAST_LINE) || (idx_q == LAST_ADDR);

  always_comb begin
    cur_byte = hex_char;
    case (state_q)
      S_SEP:   cur_byte = 8'h20;
      S_CR:    cur_byte = 8'h0D;
      S_LF:    cur_byte = 8'h0A;
      default: cur_byte = hex_char;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    line_d     = line_q;
    word_d     = word_q;
    dig_d      = dig_q;
    tx_dat_d   = tx_dat_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // done_q high means this is the done cycle; a start here is dropped.
        if (start_i && !done_q) begin
          state_d = S_ADDR;
          busy_d  = 1'b1;
          idx_d   = '0;
          line_d  = '0;
        end
      end

      S_ADDR: state_d = S_LATCH;

      S_LATCH: begin
        word_d  = WORD_W'(rd_data_i);
        dig_d   = DIG_TOP;
        phase_d = PH_SEND;
        state_d = S_DIGIT;
      end

      S_DIGIT, S_SEP, S_CR, S_LF: begin
        if (phase_q == PH_SEND) begin
          if (!tx_busy_i) begin
            tx_start_d = 1'b1;
            tx_dat_d   = cur_byte;
            phase_d    = PH_GAP;
          end
        end else begin
          // GAP: tx_busy is not yet valid for the byte just triggered.
          phase_d = PH_SEND;
          case (state_q)
            S_DIGIT: begin
              if (dig_q != '0) begin
                dig_d = dig_q - DIG_ONE;
              end else if (end_of_line) begin
                line_d  = '0;
                state_d = S_CR;
              end else begin
                line_d  = line_q + LINE_ONE;
                state_d = S_SEP;
              end
            end
            S_CR: state_d = S_LF;
            default: begin
              if (idx_q == LAST_ADDR) begin
                state_d = S_DRAIN;
              end else begin
                idx_d   = idx_q + ADDR_ONE;
                state_d = S_ADDR;
              end
            end
          endcase
        end
      end

      S_DRAIN: begin
        // Entered two cycles after the last tx_start, so tx_busy is meaningful.
        if (!tx_busy_i) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_SEND;
      idx_q      <= '0;
      line_q     <= '0;
      word_q     <= '0;
      dig_q      <= '0;
      tx_dat_q   <= 8'h00;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      line_q     <= line_d;
      word_q     <= word_d;
      dig_q      <= dig_d;
      tx_dat_q   <= tx_dat_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign rd_addr_o  = idx_q;
  assign tx_dat_o   = tx_dat_q;
  assign tx_start_o = tx_start_q;

endmodule

// File: tb/tb_hex_frame_dumper.sv
// tb/tb_hex_frame_dumper.sv - self-checking bench for hex_frame_dumper
module tb_hex_frame_dumper;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 0: 16b/4/2, instance 1: 10b/3/8, instance 2: 8b/5/1.
  int dw[3]  = '{16, 10, 8};
  int dep[3] = '{4, 3, 5};
  int wpl[3] = '{2, 8, 1};

  logic       st[3];
  logic       bz[3];
  logic       dn[3];
  logic       txs[3];
  logic       txb[3];
  logic [7:0] txd[3];
  logic [1:0] a0, a1;
  logic [2:0] a2;
  logic [15:0] mem[3][8];
  logic [15:0] rdd[3];

  int cnt[3];
  int blen[3];
  int last[3];
  int viol[3];
  int ndone[3];
  int maxaddr;
  int cyc;
  byte unsigned cap[3][$];
  byte unsigned exp_q[$];

  int checks = 0;
  int errors = 0;

  hex_frame_dumper #(.DATA_W(16), .DEPTH(4), .WORDS_PER_LINE(2)) u0 (
    .clk(clk), .rst(rst), .start_i(st[0]), .busy_o(bz[0]), .done_o(dn[0]),
    .rd_addr_o(a0), .rd_data_i(rdd[0]), .tx_dat_o(txd[0]),
    .tx_start_o(txs[0]), .tx_busy_i(txb[0]));

  hex_frame_dumper #(.DATA_W(10), .DEPTH(3), .WORDS_PER_LINE(8)) u1 (
    .clk(clk), .rst(rst), .start_i(st[1]), .busy_o(bz[1]), .done_o(dn[1]),
    .rd_addr_o(a1), .rd_data_i(rdd[1][9:0]), .tx_dat_o(txd[1]),
    .tx_start_o(txs[1]), .tx_busy_i(txb[1]));

  hex_frame_dumper #(.DATA_W(8), .DEPTH(5), .WORDS_PER_LINE(1)) u2 (
    .clk(clk), .rst(rst), .start_i(st[2]), .busy_o(bz[2]), .done_o(dn[2]),
    .rd_addr_o(a2), .rd_data_i(rdd[2][7:0]), .tx_dat_o(txd[2]),
    .tx_start_o(txs[2]), .tx_busy_i(txb[2]));

  always @(posedge clk) begin
    rdd[0] <= mem[0][a0];
    rdd[1] <= mem[1][a1];
    rdd[2] <= mem[2][a2];
  end

  always_comb begin
    for (int k = 0; k < 3; k++) txb[k] = (cnt[k] != 0);
  end

  // UART models: capture bytes, stay busy blen cycles, flag protocol abuse.
  always @(posedge clk) begin
    cyc++;
    if (int'(a2) > maxaddr) maxaddr = int'(a2);
    for (int k = 0; k < 3; k++) begin
      if (dn[k]) ndone[k]++;
      if (txs[k]) begin
        cap[k].push_back(txd[k]);
        if ((cyc - last[k]) < 2 || cnt[k] != 0) viol[k]++;
        last[k] = cyc;
        cnt[k] <= blen[k];
      end else if (cnt[k] != 0) begin
        cnt[k] <= cnt[k] - 1;
      end
    end
  end

  function automatic void build_exp(int k);
    int nib, v, n;
    exp_q.delete();
    nib = (dw[k] + 3) / 4;
    for (int i = 0; i < dep[k]; i++) begin
      v = int'(mem[k][i]) & ((1 << dw[k]) - 1);
      for (int d = nib - 1; d >= 0; d--) begin
        n = (v >> (4 * d)) & 15;
        exp_q.push_back(byte'(n < 10 ? 48 + n : 55 + n));
      end
      if (((i + 1) % wpl[k]) == 0 || i == dep[k] - 1) begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end else begin
        exp_q.push_back(8'h20);
      end
    end
  endfunction

  function automatic int first_diff(int k);
    if (cap[k].size() != exp_q.size()) return 9999;
    for (int i = 0; i < exp_q.size(); i++)
      if (cap[k][i] !== exp_q[i]) return i;
    return -1;
  endfunction

  function automatic int str_diff(int k, string s);
    if (cap[k].size() != s.len()) return 9999;
    for (int i = 0; i < s.len(); i++)
      if (cap[k][i] !== s[i]) return i;
    return -1;
  endfunction

  task automatic fill_random(int k);
    for (int i = 0; i < 8; i++) mem[k][i] = 16'($urandom);
  endtask

  task automatic start_frame(int k);
    @(negedge clk) st[k] = 1'b1;
    @(negedge clk) st[k] = 1'b0;
  endtask

  task automatic wait_done(int k, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (dn[k]) begin
        timed_out = 1'b0;
        return;
      end
    end
  endtask

  task automatic do_frame(int k, output bit timed_out);
    cap[k].delete();
    ndone[k] = 0;
    viol[k]  = 0;
    start_frame(k);
    wait_done(k, timed_out);
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({bz[k], dn[k], txs[k], txd[k]} !== 11'b0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d got busy=%b done=%b tx_start=%b tx_dat=%h want all 0",
                 k, bz[k], dn[k], txs[k], txd[k]);
      end
    end
    checks++;
    if ({a0, a1, a2} !== 7'b0) begin
      errors++;
      $display("FAIL reset_rd_addr got %h %h %h want 0", a0, a1, a2);
    end
  endtask

  task automatic test_fixed_frame(int k, string want, int busy_cycles);
    bit to;
    blen[k] = busy_cycles;
    do_frame(k, to);
    build_exp(k);
    checks++;
    if (to) begin errors++; $display("FAIL fixed_done_timeout inst%0d got timeout want done", k); end
    checks++;
    if (str_diff(k, want) != -1) begin
      errors++;
      $display("FAIL fixed_text inst%0d got %0d bytes diff_at=%0d want %0d bytes", k, cap[k].size(), str_diff(k, want), want.len());
    end
    checks++;
    if (first_diff(k) != -1) begin
      errors++;
      $display("FAIL fixed_model inst%0d got diff_at=%0d want -1", k, first_diff(k));
    end
    checks++;
    if (ndone[k] != 1 || bz[k] !== 1'b0) begin
      errors++;
      $display("FAIL fixed_done_busy inst%0d got done_pulses=%0d busy=%b want 1 and 0", k, ndone[k], bz[k]);
    end
    checks++;
    if (viol[k] != 0) begin
      errors++;
      $display("FAIL fixed_protocol inst%0d got violations=%0d want 0", k, viol[k]);
    end
  endtask

  task automatic test_config1;
    mem[0][0] = 16'h1234; mem[0][1] = 16'hABCD; mem[0][2] = 16'h0000; mem[0][3] = 16'hFFFF;
    test_fixed_frame(0, "1234 ABCD\r\n0000 FFFF\r\n", 10);
  endtask

  task automatic test_config2;
    mem[1][0] = 16'h03FF; mem[1][1] = 16'h0001; mem[1][2] = 16'h02A5;
    test_fixed_frame(1, "3FF 001 2A5\r\n", 4);
  endtask

  task automatic test_busy_zero;
    bit to;
    fill_random(0);
    blen[0] = 0;
    do_frame(0, to);
    build_exp(0);
    checks++;
    if (to || cap[0].size() != 22) begin
      errors++;
      $display("FAIL busy0_count got %0d bytes timeout=%b want 22", cap[0].size(), to);
    end
    checks++;
    if (viol[0] != 0) begin
      errors++;
      $display("FAIL busy0_spacing got violations=%0d want 0", viol[0]);
    end
    checks++;
    if (first_diff(0) != -1) begin
      errors++;
      $display("FAIL busy0_data got diff_at=%0d want -1", first_diff(0));
    end
  endtask

  task automatic test_random;
    bit to;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++) begin
        fill_random(k);
        blen[k] = int'($urandom_range(0, 12));
        do_frame(k, to);
        build_exp(k);
        checks++;
        if (to || first_diff(k) != -1 || ndone[k] != 1 || viol[k] != 0) begin
          errors++;
          $display("FAIL random_frame inst%0d round%0d got diff_at=%0d done=%0d viol=%0d timeout=%b want -1/1/0/0",
                   k, r, first_diff(k), ndone[k], viol[k], to);
        end
      end
    end
  endtask

  task automatic test_start_ignored;
    bit to;
    fill_random(0);
    blen[0] = 3;
    cap[0].delete();
    ndone[0] = 0;
    viol[0]  = 0;
    start_frame(0);
    to = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (dn[0]) begin
        to = 1'b0;
        break;
      end
      st[0] = ((i % 37) == 5);
    end
    st[0] = 1'b1;           // held through the done cycle
    @(negedge clk) st[0] = 1'b0;
    repeat (80) @(negedge clk);
    build_exp(0);
    checks++;
    if (to || first_diff(0) != -1) begin
      errors++;
      $display("FAIL start_ignored_data got %0d bytes diff_at=%0d timeout=%b want %0d bytes", cap[0].size(), first_diff(0), to, exp_q.size());
    end
    checks++;
    if (ndone[0] != 1 || bz[0] !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored_done got done_pulses=%0d busy=%b want 1 and 0", ndone[0], bz[0]);
    end
  endtask

  task automatic test_reset_mid;
    bit to;
    fill_random(0);
    blen[0] = 6;
    cap[0].delete();
    start_frame(0);
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (cap[0].size() >= 5) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    checks++;
    if (to || {bz[0], dn[0], txs[0], txd[0], a0} !== 13'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs got busy=%b done=%b tx_start=%b tx_dat=%h addr=%h timeout=%b want 0",
               bz[0], dn[0], txs[0], txd[0], a0, to);
    end
    repeat (60) @(negedge clk);
    checks++;
    if (cap[0].size() != 5) begin
      errors++;
      $display("FAIL reset_mid_quiet got %0d bytes want 5", cap[0].size());
    end
    fill_random(0);
    do_frame(0, to);
    build_exp(0);
    checks++;
    if (to || first_diff(0) != -1 || ndone[0] != 1) begin
      errors++;
      $display("FAIL reset_mid_restart got diff_at=%0d done=%0d timeout=%b want -1/1", first_diff(0), ndone[0], to);
    end
  endtask

  task automatic test_depth5;
    bit to;
    int crlf;
    fill_random(2);
    blen[2] = 2;
    maxaddr = 0;
    do_frame(2, to);
    build_exp(2);
    crlf = 0;
    for (int i = 1; i < cap[2].size(); i++)
      if (cap[2][i-1] == 8'h0D && cap[2][i] == 8'h0A) crlf++;
    checks++;
    if (maxaddr > 4) begin
      errors++;
      $display("FAIL depth5_addr got max rd_addr=%0d want <=4", maxaddr);
    end
    checks++;
    if (to || crlf != 5 || first_diff(2) != -1) begin
      errors++;
      $display("FAIL depth5_lines got crlf=%0d diff_at=%0d timeout=%b want 5/-1", crlf, first_diff(2), to);
    end
  endtask

  initial begin
    cyc = 0;
    maxaddr = 0;
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0;
      cnt[k] = 0;
      blen[k] = 0;
      last[k] = -100;
      viol[k] = 0;
      ndone[k] = 0;
      for (int i = 0; i < 8; i++) mem[k][i] = '0;
    end
    rst = 1'b1;
    test_reset();
    test_config1();
    test_config2();
    test_busy_zero();
    test_random();
    test_start_ignored();
    test_reset_mid();
    test_depth5();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
